// File: rtl/dqbus_pkg.sv
// Shared types and elaboration helpers for the DQ/DQS bus scheduler.
package dqbus_pkg;

   typedef enum logic {
      DIR_WR = 1'b0,
      DIR_RD = 1'b1
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRE   = 2'd1,
      ST_BURST = 2'd2,
      ST_POST  = 2'd3
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic bit params_ok(input int bl, input int turn_cyc, input int pre_cyc,
                                    input int post_cyc, input int max_same);
      return (bl >= 4) && (bl % 2 == 0) && (turn_cyc >= 0) && (turn_cyc <= 15) &&
             (pre_cyc >= 1) && (post_cyc >= 1) && (max_same >= 1);
   endfunction

endpackage

// File: rtl/dqbus_arb.sv
// Direction pick and grant eligibility for an IDLE-cycle decision.
module dqbus_arb
   import dqbus_pkg::*;
#(
   parameter int MAX_SAME = 4,
   parameter int TURN_CYC = 2,
   parameter int SAME_W   = 3,
   parameter int GAP_W    = 2
) (
   input  logic              i_wr_req,
   input  logic              i_rd_req,
   input  logic              i_last_vld,
   input  dir_e              i_last_dir,
   input  logic [SAME_W-1:0] i_same_cnt,
   input  logic [GAP_W-1:0]  i_gap_cnt,
   output logic              o_gnt_vld,
   output dir_e              o_gnt_dir,
   output logic              o_same_full
);

   logic w_gap_ok;
   logic w_same_req;
   logic w_opp_req;
   dir_e w_opp_dir;

   assign o_same_full = (i_same_cnt == SAME_W'(MAX_SAME));
   assign w_gap_ok    = (i_gap_cnt == GAP_W'(TURN_CYC));
   assign w_same_req  = (i_last_dir == DIR_WR) ? i_wr_req : i_rd_req;
   assign w_opp_req   = (i_last_dir == DIR_WR) ? i_rd_req : i_wr_req;
   assign w_opp_dir   = (i_last_dir == DIR_WR) ? DIR_RD : DIR_WR;

   always_comb begin
      o_gnt_vld = 1'b0;
      o_gnt_dir = DIR_WR;
      if (!i_last_vld) begin
         // fresh bus: no turnaround owed, write wins a tie
         if (i_wr_req) begin
            o_gnt_vld = 1'b1;
            o_gnt_dir = DIR_WR;
         end else if (i_rd_req) begin
            o_gnt_vld = 1'b1;
            o_gnt_dir = DIR_RD;
         end
      end else if (w_same_req && !(w_opp_req && o_same_full)) begin
         o_gnt_vld = 1'b1;
         o_gnt_dir = i_last_dir;
      end else if (w_opp_req && w_gap_ok) begin
         o_gnt_vld = 1'b1;
         o_gnt_dir = w_opp_dir;
      end
   end

endmodule

// File: rtl/dqbus_sched.sv
// DQ/DQS bus scheduler: grants read/write bursts, enforces turnaround,
// and produces registered PHY output enables and the read capture gate.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | bus released; arbitrate, count turnaround gap
//   ST_PRE   | DQS preamble, PRE_CYC clocks
//   ST_BURST | data beats, BL/2 clocks per grant; may chain seamlessly
//   ST_POST  | DQS postamble, POST_CYC clocks, then bus released
module dqbus_sched
   import dqbus_pkg::*;
#(
   parameter int BL       = 8,
   parameter int TURN_CYC = 2,
   parameter int PRE_CYC  = 1,
   parameter int POST_CYC = 1,
   parameter int MAX_SAME = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic wr_req,
   input  logic rd_req,
   output logic wr_gnt,
   output logic rd_gnt,
   output logic dq_oe,
   output logic dqs_oe,
   output logic dqs_gate,
   output logic burst_last,
   output logic busy
);

   localparam int HALF    = BL / 2;
   localparam int CNT_MAX = max_int(max_int(HALF, PRE_CYC), POST_CYC);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SAME_W  = $clog2(MAX_SAME + 1);
   localparam int GAP_W   = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;

   localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRE_CYC - 1);
   localparam logic [CNT_W-1:0] BURST_LD = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] POST_LD  = CNT_W'(POST_CYC - 1);

   if (!params_ok(BL, TURN_CYC, PRE_CYC, POST_CYC, MAX_SAME)) begin : g_bad_params
      $error("dqbus_sched: illegal parameter set");
   end

   state_e            r_state, w_state_nxt;
   dir_e              r_dir, w_dir_nxt;
   dir_e              r_last_dir, w_last_dir_nxt;
   logic              r_last_vld, w_last_vld_nxt;
   logic [SAME_W-1:0] r_same_cnt, w_same_nxt, w_same_inc;
   logic [GAP_W-1:0]  r_gap_cnt, w_gap_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              w_gnt;
   logic              w_arb_vld;
   dir_e              w_arb_dir;
   logic              w_same_full;
   logic              w_cur_req;
   logic              w_oth_req;
   logic              w_seam;

   logic r_wr_gnt, r_rd_gnt, r_dq_oe, r_dqs_oe, r_dqs_gate, r_burst_last, r_busy;

   dqbus_arb #(
      .MAX_SAME (MAX_SAME),
      .TURN_CYC (TURN_CYC),
      .SAME_W   (SAME_W),
      .GAP_W    (GAP_W)
   ) u_arb (
      .i_wr_req    (wr_req),
      .i_rd_req    (rd_req),
      .i_last_vld  (r_last_vld),
      .i_last_dir  (r_last_dir),
      .i_same_cnt  (r_same_cnt),
      .i_gap_cnt   (r_gap_cnt),
      .o_gnt_vld   (w_arb_vld),
      .o_gnt_dir   (w_arb_dir),
      .o_same_full (w_same_full)
   );

   assign w_same_inc = w_same_full ? r_same_cnt : r_same_cnt + SAME_W'(1);
   assign w_cur_req  = (r_dir == DIR_WR) ? wr_req : rd_req;
   assign w_oth_req  = (r_dir == DIR_WR) ? rd_req : wr_req;
   // chain another burst unless the waiting opposite side has used up its patience
   assign w_seam     = w_cur_req && !(w_oth_req && w_same_full);

   always_comb begin
      w_state_nxt    = r_state;
      w_dir_nxt      = r_dir;
      w_last_dir_nxt = r_last_dir;
      w_last_vld_nxt = r_last_vld;
      w_same_nxt     = r_same_cnt;
      w_gap_nxt      = r_gap_cnt;
      w_cnt_nxt      = r_cnt;
      w_gnt          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_arb_vld) begin
               w_state_nxt = ST_PRE;
               w_cnt_nxt   = PRE_LD;
               w_dir_nxt   = w_arb_dir;
               w_gnt       = 1'b1;
               w_same_nxt  = (r_last_vld && (w_arb_dir == r_last_dir)) ? w_same_inc
                                                                         : SAME_W'(1);
            end else if (r_gap_cnt != GAP_W'(TURN_CYC)) begin
               w_gap_nxt = r_gap_cnt + GAP_W'(1);
            end
         end
         ST_PRE: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_BURST;
               w_cnt_nxt   = BURST_LD;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_BURST: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else if (w_seam) begin
               w_cnt_nxt  = BURST_LD;
               w_gnt      = 1'b1;
               w_same_nxt = w_same_inc;
            end else begin
               w_state_nxt = ST_POST;
               w_cnt_nxt   = POST_LD;
            end
         end
         ST_POST: begin
            if (r_cnt == '0) begin
               w_state_nxt    = ST_IDLE;
               w_gap_nxt      = '0;
               w_last_dir_nxt = r_dir;
               w_last_vld_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_dir        <= DIR_WR;
         r_last_dir   <= DIR_WR;
         r_last_vld   <= 1'b0;
         r_same_cnt   <= '0;
         r_gap_cnt    <= GAP_W'(TURN_CYC);
         r_cnt        <= '0;
         r_wr_gnt     <= 1'b0;
         r_rd_gnt     <= 1'b0;
         r_dq_oe      <= 1'b0;
         r_dqs_oe     <= 1'b0;
         r_dqs_gate   <= 1'b0;
         r_burst_last <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_dir        <= w_dir_nxt;
         r_last_dir   <= w_last_dir_nxt;
         r_last_vld   <= w_last_vld_nxt;
         r_same_cnt   <= w_same_nxt;
         r_gap_cnt    <= w_gap_nxt;
         r_cnt        <= w_cnt_nxt;
         r_wr_gnt     <= w_gnt && (w_dir_nxt == DIR_WR);
         r_rd_gnt     <= w_gnt && (w_dir_nxt == DIR_RD);
         r_dq_oe      <= (w_state_nxt == ST_BURST) && (w_dir_nxt == DIR_WR);
         r_dqs_oe     <= (w_state_nxt != ST_IDLE) && (w_dir_nxt == DIR_WR);
         r_dqs_gate   <= (w_state_nxt != ST_IDLE) && (w_dir_nxt == DIR_RD);
         r_burst_last <= (w_state_nxt == ST_BURST) && (w_cnt_nxt == '0);
         r_busy       <= (w_state_nxt != ST_IDLE);
      end
   end

   assign wr_gnt     = r_wr_gnt;
   assign rd_gnt     = r_rd_gnt;
   assign dq_oe      = r_dq_oe;
   assign dqs_oe     = r_dqs_oe;
   assign dqs_gate   = r_dqs_gate;
   assign burst_last = r_burst_last;
   assign busy       = r_busy;

endmodule

// File: tb/tb_dqbus_sched.sv
// Bench for dqbus_sched: a timeline model that books PRE/BURST/POST windows
// per grant, directed scenarios with fixed-cycle spot checks, then random traffic.
module tb_dqbus_sched;

   localparam int BL = 8, TURN = 2, PRE = 1, POST = 1, MAXS = 4, H = BL / 2;
   localparam int NC = 4096;

   logic clk = 1'b0;
   logic rst_n;
   logic wr_req, rd_req;
   logic wr_gnt, rd_gnt, dq_oe, dqs_oe, dqs_gate, burst_last, busy;
   logic wr2, rd2;
   logic wr_gnt2, rd_gnt2, dq_oe2, dqs_oe2, dqs_gate2, burst_last2, busy2;

   dqbus_sched #(.BL(BL), .TURN_CYC(TURN), .PRE_CYC(PRE), .POST_CYC(POST), .MAX_SAME(MAXS)) dut (
      .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req),
      .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .dq_oe(dq_oe), .dqs_oe(dqs_oe),
      .dqs_gate(dqs_gate), .burst_last(burst_last), .busy(busy));

   dqbus_sched #(.BL(4), .TURN_CYC(0), .PRE_CYC(2), .POST_CYC(1), .MAX_SAME(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .wr_req(wr2), .rd_req(rd2),
      .wr_gnt(wr_gnt2), .rd_gnt(rd_gnt2), .dq_oe(dq_oe2), .dqs_oe(dqs_oe2),
      .dqs_gate(dqs_gate2), .burst_last(burst_last2), .busy(busy2));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // expected outputs per absolute cycle
   bit e_wg[NC], e_rg[NC], e_dq[NC], e_dqs[NC], e_gate[NC], e_last[NC], e_busy[NC];

   // model: 0 = write, 1 = read
   int post_end, burst_end, same_cnt;
   bit last_vld, last_dir, cur_dir, gap_full;
   bit pw, pr;
   bit chk2;
   int s2;

   typedef struct {
      int    c;
      int    s;
      bit    v;
      string tag;
   } spot_t;
   spot_t spots[$];

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic spot(input int c, input int s, input bit v, input string tag);
      spot_t e;
      e.c = c; e.s = s; e.v = v; e.tag = tag;
      spots.push_back(e);
   endtask

   function automatic logic sig_val(input int s);
      case (s)
         0: return wr_gnt;
         1: return rd_gnt;
         2: return dq_oe;
         3: return dqs_oe;
         4: return dqs_gate;
         5: return burst_last;
         default: return busy;
      endcase
   endfunction

   function automatic bit in_rng(input int v, input int a, input int b);
      return (v >= a) && (v <= b);
   endfunction

   task automatic model_reset();
      for (int c = cyc; c < NC; c++) begin
         e_wg[c] = 0; e_rg[c] = 0; e_dq[c] = 0; e_dqs[c] = 0;
         e_gate[c] = 0; e_last[c] = 0; e_busy[c] = 0;
      end
      post_end = -1; burst_end = -1; same_cnt = 0;
      last_vld = 0; gap_full = 1;
   endtask

   task automatic book_strobe(input int a, input int b, input bit d);
      for (int c = a; c <= b; c++) begin
         e_busy[c] = 1;
         if (d) e_gate[c] = 1; else e_dqs[c] = 1;
      end
   endtask

   // data window starting at b0, postamble right after it
   task automatic book_burst(input int b0, input bit d);
      book_strobe(b0, b0 + H - 1, d);
      if (!d) for (int c = b0; c < b0 + H; c++) e_dq[c] = 1;
      burst_end = b0 + H - 1;
      e_last[burst_end] = 1;
      post_end = burst_end + POST;
      book_strobe(burst_end + 1, post_end, d);
   endtask

   task automatic model_step(input int t, input bit w, input bit r);
      int gap;
      bit granted, g, want_same, want_other, pref;
      granted = 0; g = 0;
      if (t > post_end) begin
         gap = gap_full ? TURN : (t - post_end - 1);
         if (gap > TURN) gap = TURN;
         if (!last_vld) begin
            granted = w | r;
            g = !w;
         end else begin
            want_same  = last_dir ? r : w;
            want_other = last_dir ? w : r;
            // the side that gets served: the previous direction while its quota lasts
            pref = (want_other && same_cnt == MAXS) ? !last_dir : last_dir;
            if (pref == last_dir && want_same) begin
               granted = 1; g = last_dir;
            end else if (want_other && gap == TURN) begin
               granted = 1; g = !last_dir;
            end
         end
         if (granted) begin
            if (last_vld && g == last_dir) same_cnt = (same_cnt < MAXS) ? same_cnt + 1 : MAXS;
            else same_cnt = 1;
            last_dir = g; last_vld = 1; gap_full = 0; cur_dir = g;
            if (g) e_rg[t + 1] = 1; else e_wg[t + 1] = 1;
            book_strobe(t + 1, t + PRE, g);
            book_burst(t + PRE + 1, g);
         end
      end else if (t == burst_end) begin
         want_same  = cur_dir ? r : w;
         want_other = cur_dir ? w : r;
         if (want_same && !(want_other && same_cnt == MAXS)) begin
            same_cnt = (same_cnt < MAXS) ? same_cnt + 1 : MAXS;
            if (cur_dir) e_rg[t + 1] = 1; else e_wg[t + 1] = 1;
            book_burst(t + 1, cur_dir);
         end
      end
   endtask

   task automatic check_outputs();
      int rel;
      chk("wr_gnt", wr_gnt, e_wg[cyc]);
      chk("rd_gnt", rd_gnt, e_rg[cyc]);
      chk("dq_oe", dq_oe, e_dq[cyc]);
      chk("dqs_oe", dqs_oe, e_dqs[cyc]);
      chk("dqs_gate", dqs_gate, e_gate[cyc]);
      chk("burst_last", burst_last, e_last[cyc]);
      chk("busy", busy, e_busy[cyc]);
      chk("dq_vs_gate_excl", dq_oe & dqs_gate, 1'b0);
      chk("gnt_excl", wr_gnt & rd_gnt, 1'b0);
      foreach (spots[i]) if (spots[i].c == cyc) chk(spots[i].tag, sig_val(spots[i].s), spots[i].v);
      if (chk2) begin
         rel = cyc - s2;
         if (rel <= 15) begin
            chk("p2_rd_gnt", rd_gnt2, rel == 1);
            chk("p2_wr_gnt", wr_gnt2, rel == 7);
            chk("p2_dqs_gate", dqs_gate2, in_rng(rel, 1, 5));
            chk("p2_dqs_oe", dqs_oe2, in_rng(rel, 7, 11));
            chk("p2_dq_oe", dq_oe2, in_rng(rel, 9, 10));
            chk("p2_burst_last", burst_last2, rel == 4 || rel == 10);
            chk("p2_busy", busy2, in_rng(rel, 1, 5) || in_rng(rel, 7, 11));
         end
      end
   endtask

   // called just after a negedge: check this cycle, drive its inputs, advance model
   task automatic tick();
      int rel;
      check_outputs();
      if (e_wg[cyc]) pw = 0;
      if (e_rg[cyc]) pr = 0;
      wr_req = pw;
      rd_req = pr;
      rel = cyc - s2;
      rd2 = chk2 && rel == 0;
      wr2 = chk2 && in_rng(rel, 2, 6);
      if (rst_n) model_step(cyc, pw, pr);
      @(negedge clk);
   endtask

   task automatic reset_for(input int n);
      check_outputs();
      rst_n = 1'b0;
      pw = 0; pr = 0; wr_req = 0; rd_req = 0;
      #1;
      chk("rst_wr_gnt", wr_gnt, 1'b0);
      chk("rst_dq_oe", dq_oe, 1'b0);
      chk("rst_dqs_oe", dqs_oe, 1'b0);
      chk("rst_dqs_gate", dqs_gate, 1'b0);
      chk("rst_burst_last", burst_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      model_reset();
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int s;
      rst_n = 1'b0; wr_req = 0; rd_req = 0; wr2 = 0; rd2 = 0;
      pw = 0; pr = 0; chk2 = 0; s2 = -100;
      model_reset();
      repeat (3) @(negedge clk);
      model_reset();
      rst_n = 1'b1;

      // single write, then a read raised mid-burst; small-parameter instance alongside
      s = cyc; s2 = cyc; chk2 = 1;
      spot(s + 1, 0, 1, "w1_wr_gnt");
      spot(s + 2, 2, 1, "w1_dq_first");
      spot(s + 5, 5, 1, "w1_burst_last");
      spot(s + 6, 2, 0, "w1_dq_after");
      spot(s + 6, 3, 1, "w1_dqs_post");
      spot(s + 7, 6, 0, "w1_idle");
      spot(s + 9, 1, 0, "wr_gap_no_rd");
      spot(s + 10, 1, 1, "wr_rd_gnt");
      spot(s + 10, 4, 1, "wr_gate_first");
      spot(s + 15, 4, 1, "wr_gate_last");
      spot(s + 16, 4, 0, "wr_gate_off");
      for (int k = 0; k < 24; k++) begin
         if (k == 0) pw = 1;
         if (k == 3) pr = 1;
         tick();
      end
      chk2 = 0;

      // back-to-back writes
      reset_for(2);
      s = cyc;
      spot(s + 6, 0, 1, "b2b_wr_gnt2");
      spot(s + 6, 2, 1, "b2b_dq_cont");
      spot(s + 9, 5, 1, "b2b_last2");
      spot(s + 10, 3, 1, "b2b_post");
      spot(s + 10, 2, 0, "b2b_dq_end");
      spot(s + 11, 3, 0, "b2b_dqs_end");
      for (int k = 0; k < 16; k++) begin
         if (k == 0 || k == 3) pw = 1;
         tick();
      end

      // starvation: writes always requested, one read waiting
      reset_for(2);
      s = cyc;
      spot(s + 14, 0, 1, "stv_wr4");
      spot(s + 18, 0, 0, "stv_no_wr5");
      spot(s + 18, 3, 1, "stv_post");
      spot(s + 19, 6, 0, "stv_gap");
      spot(s + 22, 1, 1, "stv_rd_gnt");
      spot(s + 27, 4, 1, "stv_rd_post");
      spot(s + 31, 0, 1, "stv_wr_after");
      for (int k = 0; k < 44; k++) begin
         pw = 1;
         if (k == 0) pr = 1;
         tick();
      end
      pw = 0;
      repeat (12) tick();

      // reset in the middle of a write burst
      reset_for(2);
      s = cyc;
      spot(s + 3, 2, 1, "rst_mid_dq");
      spot(s + 6, 0, 1, "rst_regrant");
      for (int k = 0; k < 3; k++) begin
         if (k == 0) pw = 1;
         tick();
      end
      reset_for(2);
      pw = 1;
      repeat (14) tick();

      // random traffic
      reset_for(2);
      for (int k = 0; k < 1600; k++) begin
         if (k == 800) reset_for(1);
         if (!pw && $urandom_range(0, 3) == 0) pw = 1;
         if (!pr && $urandom_range(0, 4) == 0) pr = 1;
         tick();
      end
      pw = 0; pr = 0;
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
